// File: rtl/secuenciador_bus_rtc_pkg.sv
// Shared types and default timing for the RTC multiplexed-bus sequencer.
package secuenciador_bus_rtc_pkg;

    localparam int unsigned T_PULSE_DEF  = 8;
    localparam int unsigned T_GAP_DEF    = 4;
    localparam int unsigned HOLD_OFF_DEF = 3;

    localparam int unsigned BUS_W  = 8;
    localparam int unsigned TMR_W  = 4;
    localparam int unsigned HOLD_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_SET,
        S_ADDR_DRV,
        S_ADDR_GAP,
        S_DATA_SET,
        S_DATA_DRV,
        S_DATA_GAP,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_ESC,
        G_LECT
    } grant_t;

endpackage

// File: rtl/secuenciador_bus_rtc_if.sv
// Requester handshake plus RTC pin bundle shared by the sequencer and its environment.
interface secuenciador_bus_rtc_if;
    import secuenciador_bus_rtc_pkg::*;

    logic             E_esc;
    logic             E_lect;
    logic [BUS_W-1:0] Dato_Dire;
    logic [BUS_W-1:0] Dir_lect;
    logic [BUS_W-1:0] AD_in;
    logic             DIR_esc;
    logic             DAT_esc;
    logic             cambio_esc;
    logic             DIR_lect;
    logic             DAT_lect;
    logic             cambio_lect;
    logic [BUS_W-1:0] AD_out;
    logic             AD_oe;
    logic             CS_n;
    logic             RD_n;
    logic             WR_n;
    logic             A_D;
    logic [BUS_W-1:0] Dato_Leido;
    logic             Ocupado;

    modport slave (
        input  E_esc, E_lect, Dato_Dire, Dir_lect, AD_in,
        output DIR_esc, DAT_esc, cambio_esc, DIR_lect, DAT_lect, cambio_lect,
        output AD_out, AD_oe, CS_n, RD_n, WR_n, A_D, Dato_Leido, Ocupado
    );

    modport master (
        output E_esc, E_lect, Dato_Dire, Dir_lect, AD_in,
        input  DIR_esc, DAT_esc, cambio_esc, DIR_lect, DAT_lect, cambio_lect,
        input  AD_out, AD_oe, CS_n, RD_n, WR_n, A_D, Dato_Leido, Ocupado
    );

endinterface

// File: rtl/secuenciador_bus_rtc_temporizador_fase.sv
// Loadable 4-bit down-counter with zero flag, shared by all timed bus phases.
module temporizador_fase
    import secuenciador_bus_rtc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cnt <= '0;
        else if (load)          cnt <= load_val;
        else if (cnt != '0)     cnt <= cnt - TMR_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/secuenciador_bus_rtc.sv
// Arbitrates the RTC address/data port between the write and read machines and
// sequences the address and data phases of each bus cycle.
module secuenciador_bus_rtc
    import secuenciador_bus_rtc_pkg::*;
#(
    parameter int unsigned T_PULSE  = T_PULSE_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF,
    parameter int unsigned HOLD_OFF = HOLD_OFF_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    secuenciador_bus_rtc_if.slave bus
);

    state_t           state;
    grant_t           grant;
    grant_t           last_served;
    logic [HOLD_W-1:0] idle_cnt;
    logic             post_fin;
    logic             owner_en;
    logic             is_wr;
    logic             is_rd;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;

    assign is_wr    = (grant == G_ESC);
    assign is_rd    = (grant == G_LECT);
    assign owner_en = (is_wr & bus.E_esc) | (is_rd & bus.E_lect);

    // Read address is only driven during its address phase; write data follows the grant.
    assign bus.AD_out = is_wr ? bus.Dato_Dire :
                        (is_rd && (state == S_ADDR_SET || state == S_ADDR_DRV)) ? bus.Dir_lect :
                        '0;

    // Pulse phases load on entry from the set states, gap phases load as a pulse expires.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TMR_W'(T_GAP - 1);
        if (state == S_ADDR_SET || state == S_DATA_SET) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(T_PULSE - 1);
        end else if ((state == S_ADDR_DRV || state == S_DATA_DRV) && tmr_zero) begin
            tmr_load = 1'b1;
        end
    end

    temporizador_fase u_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            grant           <= G_NONE;
            last_served     <= G_NONE;
            idle_cnt        <= '0;
            post_fin        <= 1'b0;
            bus.DIR_esc     <= 1'b0;
            bus.DAT_esc     <= 1'b0;
            bus.cambio_esc  <= 1'b0;
            bus.DIR_lect    <= 1'b0;
            bus.DAT_lect    <= 1'b0;
            bus.cambio_lect <= 1'b0;
            bus.AD_oe       <= 1'b0;
            bus.CS_n        <= 1'b1;
            bus.RD_n        <= 1'b1;
            bus.WR_n        <= 1'b1;
            bus.A_D         <= 1'b1;
            bus.Dato_Leido  <= '0;
            bus.Ocupado     <= 1'b0;
        end else begin
            bus.DIR_esc     <= 1'b0;
            bus.DAT_esc     <= 1'b0;
            bus.cambio_esc  <= 1'b0;
            bus.DIR_lect    <= 1'b0;
            bus.DAT_lect    <= 1'b0;
            bus.cambio_lect <= 1'b0;
            post_fin        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant == G_NONE) begin
                        idle_cnt <= '0;
                        if (bus.E_esc && (!bus.E_lect || last_served != G_ESC)) begin
                            grant       <= G_ESC;
                            bus.Ocupado <= 1'b1;
                        end else if (bus.E_lect) begin
                            grant       <= G_LECT;
                            bus.Ocupado <= 1'b1;
                        end
                    end else if (owner_en && !post_fin) begin
                        state        <= S_ADDR_SET;
                        idle_cnt     <= '0;
                        last_served  <= grant;
                        bus.DIR_esc  <= is_wr;
                        bus.DIR_lect <= is_rd;
                    end else if (!owner_en) begin
                        // Release only after a sustained idle request, not a one-cycle dip.
                        if (idle_cnt == HOLD_W'(HOLD_OFF - 1)) begin
                            grant       <= G_NONE;
                            bus.Ocupado <= 1'b0;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + HOLD_W'(1);
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                S_ADDR_SET: begin
                    state     <= S_ADDR_DRV;
                    bus.A_D   <= 1'b0;
                    bus.CS_n  <= 1'b0;
                    bus.WR_n  <= 1'b0;
                    bus.AD_oe <= 1'b1;
                end
                S_ADDR_DRV: begin
                    if (tmr_zero) begin
                        state     <= S_ADDR_GAP;
                        bus.A_D   <= 1'b1;
                        bus.CS_n  <= 1'b1;
                        bus.WR_n  <= 1'b1;
                        bus.AD_oe <= 1'b0;
                    end
                end
                S_ADDR_GAP: begin
                    if (tmr_zero) begin
                        state       <= S_DATA_SET;
                        bus.DAT_esc <= is_wr;
                    end
                end
                S_DATA_SET: begin
                    state     <= S_DATA_DRV;
                    bus.A_D   <= 1'b1;
                    bus.CS_n  <= 1'b0;
                    bus.WR_n  <= !is_wr;
                    bus.RD_n  <= is_wr;
                    bus.AD_oe <= is_wr;
                end
                S_DATA_DRV: begin
                    if (tmr_zero) begin
                        state        <= S_DATA_GAP;
                        bus.CS_n     <= 1'b1;
                        bus.WR_n     <= 1'b1;
                        bus.RD_n     <= 1'b1;
                        bus.AD_oe    <= 1'b0;
                        bus.DAT_lect <= is_rd;
                        if (is_rd) bus.Dato_Leido <= bus.AD_in;
                    end
                end
                S_DATA_GAP: begin
                    if (tmr_zero) begin
                        state           <= S_FIN;
                        bus.cambio_esc  <= is_wr;
                        bus.cambio_lect <= is_rd;
                    end
                end
                S_FIN: begin
                    state    <= S_IDLE;
                    post_fin <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/secuenciador_bus_rtc.md
Name: secuenciador_bus_rtc

Overview:
- Bus-cycle sequencer and arbiter for the RTC's multiplexed address/data port.
- Shares the port between the write machine and the read machine.
- For the granted machine it generates the DIR / DAT / cambio_estado strobes and drives the parallel bus: AD, CS_n, RD_n, WR_n, A_D.
- Sits between the top-level controller's write/read machines and the RTC pins.

Parameters:
- T_PULSE, 8, clk cycles CS_n and WR_n/RD_n are held low per phase (1..15).
- T_GAP, 4, clk cycles of bus idle after each phase (1..15).
- HOLD_OFF, 3, consecutive idle cycles with the owner's enable low before its grant is released (2..7).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- E_esc  in  1  write machine requests a transfer
- E_lect  in  1  read machine requests a transfer
- Dato_Dire  in  8  address/data from the write machine
- Dir_lect  in  8  address from the read machine
- AD_in  in  8  bus read-back from the pad
- DIR_esc, DAT_esc, cambio_esc  out  1 each  write-machine strobes
- DIR_lect, DAT_lect, cambio_lect  out  1 each  read-machine strobes
- AD_out  out  8  bus drive value
- AD_oe  out  1  pad output enable
- CS_n, RD_n, WR_n  out  1 each  RTC controls, active low
- A_D  out  1  0 = address phase, 1 = data phase
- Dato_Leido  out  8  captured read data
- Ocupado  out  1  a grant is active

Behaviour:
- Reset (async, active-high) forces:
  - CS_n = RD_n = WR_n = A_D = 1; AD_oe = 0; AD_out = 0.
  - All strobes 0; Dato_Leido = 0; Ocupado = 0; no grant; FSM in IDLE; counters 0.
- Reset mid-transfer abandons the cycle and releases the bus immediately.
- Outputs:
  - All outputs are registered except AD_out.
  - AD_out = granted source (Dato_Dire for write; Dir_lect in the address phase of a read), else 0.
- Strobes:
  - Each strobe is a single-cycle pulse.
  - Strobes go only to the granted requester; the other requester's strobes stay 0.
- Arbitration (in IDLE only):
  - No grant and exactly one enable high → grant it.
  - Both high → grant the requester not served last (round-robin); the first contention after reset goes to write.
  - The grant is kept across transfers, so a requester's 1-cycle enable dip between registers does not lose the bus.
  - The grant is released after HOLD_OFF consecutive IDLE cycles with the owner's enable low.
- FSM (timers load T-1 and decrement; a state exits when its timer reaches 0):
  - IDLE: granted and owner enable = 1 → ADDR_SET.
  - ADDR_SET: 1 cycle; DIR strobe → ADDR_DRV.
  - ADDR_DRV: T_PULSE cycles; A_D = 0, CS_n = 0, WR_n = 0, AD_oe = 1 → ADDR_GAP.
  - ADDR_GAP: T_GAP cycles; all controls high, AD_oe = 0 → DATA_SET.
  - DATA_SET: 1 cycle; DAT strobe on write only → DATA_DRV.
  - DATA_DRV: T_PULSE cycles; A_D = 1, CS_n = 0.
    - Write: WR_n = 0, AD_oe = 1.
    - Read: RD_n = 0, AD_oe = 0; AD_in is captured into Dato_Leido on the last cycle.
    - → DATA_GAP.
  - DATA_GAP: T_GAP cycles, bus idle; on read, DAT strobe in the first cycle (Dato_Leido already valid) → FIN.
  - FIN: 1 cycle; cambio strobe → IDLE.
- After FIN, IDLE ignores the owner's enable for 1 cycle (the requester's enable register lags one cycle).
- Transfer length: 3 + 2·T_PULSE + 2·T_GAP cycles from IDLE exit to the cambio strobe; with defaults, 27.
- If the owner drops its enable mid-transfer, the bus cycle still completes, including cambio.
- A requester asserting its enable while the other holds the grant waits; no strobes reach it.
- CS_n never stays low across a phase boundary; the gap states guarantee ≥ T_GAP high cycles.

Decomposition:
- Shared package holds:
  - FSM state encodings (3-bit: IDLE … FIN).
  - Grant encodings (NONE, ESC, LECT).
  - Default timing constants T_PULSE, T_GAP, HOLD_OFF.
- One sub-module: temporizador_fase, a 4-bit loadable down-counter with a zero flag, instantiated once and shared by all timed states.

Test Plan:
- Single write:
  - Stimulus: E_esc = 1 with Dato_Dire = 0x21, then 0x45.
  - Response: DIR_esc pulse; AD_out = 0x21 with A_D = 0, WR_n low for 8 cycles; 4 idle cycles; DAT_esc; 0x45 with A_D = 1, WR_n low for 8 cycles; cambio_esc 27 cycles after start.
- Read:
  - Stimulus: E_lect = 1, Dir_lect = 0x22, AD_in = 0x37 during the data phase.
  - Response: RD_n low 8 cycles, AD_oe = 0; Dato_Leido = 0x37 before the DAT_lect pulse; then cambio_lect.
- Simultaneous requests after reset:
  - Stimulus: E_esc and E_lect both high.
  - Response: write served first; after write's enable is low for 3 idle cycles, read granted; no lect strobes during the write grant.
- Grant retention across the enable dip:
  - Stimulus: E_esc drops for 1 cycle after cambio_esc while E_lect = 1.
  - Response: grant stays with write; next DIR_esc follows.
- Reset mid-transfer:
  - Stimulus: assert reset during ADDR_DRV.
  - Response: in the same cycle, CS_n = WR_n = 1, AD_oe = 0, Ocupado = 0; after release, FSM is in IDLE with no pending strobes.
- Enable dropped mid-transfer:
  - Stimulus: E_esc falls during DATA_DRV.
  - Response: the cycle completes and cambio_esc pulses once.
